// File: rtl/clause_queue.sv
// Per-engine clause FIFO (first-word-fall-through) behind one arbiter output.
// Ports: clock, reset(async low), push_in/clause_in/full_out from arbiter,
// pop_in/clause_out/empty_out/count_out to the BCP engine, flush_in clears.
// Optional macro CLAUSE_QUEUE_OVERFLOW_CNT_EN adds overflow_cnt_out[7:0].
module clause_queue #(
  parameter int CLAUSE_WIDTH    = 2,
  parameter int ELEMENT_CNT     = 4,
  parameter int ELEMENT_BIT_CNT = $clog2(ELEMENT_CNT) + 1,
  parameter int DEPTH           = 4,
  localparam int W  = CLAUSE_WIDTH * ELEMENT_BIT_CNT,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_in,
  input  logic [W-1:0]  clause_in,
  output logic          full_out,
  input  logic          pop_in,
  input  logic          flush_in,
  output logic [W-1:0]  clause_out,
  output logic          empty_out,
  output logic [PW-1:0] count_out
`ifdef CLAUSE_QUEUE_OVERFLOW_CNT_EN
  ,
  output logic [7:0]    overflow_cnt_out
`endif
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          push_ok;
  logic          pop_ok;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  assign empty_out = (wr_q == rd_q);
  assign full_out  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                     (wr_q[AW] != rd_q[AW]);
  assign count_out = wr_q - rd_q;

  assign push_ok = push_in && !full_out && !flush_in;
  assign pop_ok  = pop_in && !empty_out && !flush_in;

  assign clause_out = empty_out ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_in) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + PW'(1);
      if (pop_ok)  rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= clause_in;
  end

`ifdef CLAUSE_QUEUE_OVERFLOW_CNT_EN
  logic [7:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (push_in && full_out && !flush_in && ovf_q != 8'hFF)
      ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign overflow_cnt_out = ovf_q;
`endif

endmodule

// File: doc/clause_queue.md
# clause_queue

Per-engine clause FIFO at the receiving end of the clause arbiter's distribution interface. It accepts clauses the arbiter pushes into its slot, reports `full_out` back so the arbiter skips it, and presents clauses first-word-fall-through to the downstream BCP engine. One instance sits behind each of the `output_cnt` arbiter outputs.

## Interface
- `CLAUSE_WIDTH`, default 2: literals per clause.
- `ELEMENT_CNT`, default 4: number of variables supported.
- `ELEMENT_BIT_CNT`, default `$clog2(ELEMENT_CNT)+1` (3): bits per literal.
- `DEPTH`, default 4: entries; a power of two, at least 2.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push_in`  in  1  arbiter writes `clause_in` this cycle.
- `clause_in`  in  `CLAUSE_WIDTH*ELEMENT_BIT_CNT` (6)  clause from the arbiter slot.
- `full_out`  out  1  queue holds `DEPTH` entries; goes to the arbiter's `full_in` bit.
- `pop_in`  in  1  engine consumes the head this cycle.
- `flush_in`  in  1  synchronous clear, used on backtrack.
- `clause_out`  out  6  head clause, first-word-fall-through.
- `empty_out`  out  1  queue holds 0 entries.
- `count_out`  out  `$clog2(DEPTH)+1`  current occupancy, 0 to `DEPTH`.
- `overflow_cnt_out`  out  8  saturating count of dropped pushes; present only with the macro.

## Operation
- Storage is `DEPTH` x 6-bit registers.
- `wr_ptr` and `rd_ptr` are each `$clog2(DEPTH)+1` bits. The extra MSB is a wrap bit.
- `count_out` is `wr_ptr - rd_ptr`, taken modulo `2*DEPTH`.
- `empty_out` = (`wr_ptr == rd_ptr`).
- `full_out` = index bits equal and wrap bits differ.
- Push is accepted iff `push_in && !full_out`. On accept:
  - `mem[wr_ptr[idx]] <= clause_in`;
  - `wr_ptr` increments and wraps naturally.
- Pop is accepted iff `pop_in && !empty_out`. On accept, `rd_ptr` increments.
- Full/empty decisions use the state at the start of the cycle. There is no same-cycle pass-through.
- When full, a push is dropped even if a pop is accepted in the same cycle. The pop still occurs.
- When empty, a pop is ignored even if a push is accepted in the same cycle. The push still occurs.
- When neither full nor empty, a simultaneous push and pop are both accepted; count is unchanged.
- Priority order:
  - `reset` (asynchronous) sets both pointers to 0 and `overflow_cnt_out` to 0;
  - `flush_in` (synchronous) sets both pointers to 0 and discards pushes/pops in that cycle; `overflow_cnt_out` is not cleared;
  - otherwise, push and pop behave as above.
- Storage contents are not reset.
- `clause_out` = `mem[rd_ptr[idx]]` when not empty, else all zeros.

## Timing
- Reset values:
  - `full_out` = 0;
  - `empty_out` = 1;
  - `count_out` = 0;
  - `clause_out` = 0;
  - `overflow_cnt_out` = 0.
- Reset assertion mid-operation takes effect immediately, without waiting for a clock edge. All buffered clauses are lost.
- Push to visibility latency is 1 cycle. A push at edge N makes the clause valid on `clause_out` after edge N, with `empty_out` low.
- `full_out`, `empty_out` and `count_out` are pure functions of registered pointers: glitch-free, with no combinational path from any input.
- `clause_out` depends only on registers.
- Sustained throughput is one push plus one pop per cycle.
- The arbiter samples `full_out` in the same cycle it drives `push_in`. Any push it issues while `full_out` = 1 is dropped.

## Configuration
- Macro: `CLAUSE_QUEUE_OVERFLOW_CNT_EN`.
- When defined:
  - the `overflow_cnt_out` port and an 8-bit register exist;
  - the register increments on every cycle with `push_in && full_out` and no `flush_in`;
  - it saturates at 255 and is cleared only by `reset`.
- When undefined, neither the port nor the register exists. Dropped pushes are silent and all other behaviour is identical.

## Test plan
- Reset with `reset` = 0 mid-stream after 3 pushes, no clock edge -> `count_out` = 0, `empty_out` = 1 and `clause_out` = 0 immediately.
- Push `6'b000001`, `000010`, `000011`, `000100` on consecutive cycles ->
  - `full_out` = 1 after the 4th edge;
  - `count_out` = 4;
  - `clause_out` = `000001`.
- When full, push `000111` with `pop_in` = 1 ->
  - head becomes `000010`;
  - `count_out` = 3;
  - `000111` is never output;
  - `overflow_cnt_out` = 1 (macro defined).
- When empty, push `000101` with `pop_in` = 1 -> `count_out` = 1 and `clause_out` = `000101` next cycle.
- Wrap-around: 10 cycles of simultaneous push/pop starting at count 2 -> output order matches input order exactly and `count_out` stays 2.
- Assert `flush_in` with `push_in` = 1 at count 3 -> `count_out` = 0, `empty_out` = 1, and the pushed clause is discarded.
